popcount_acc: RTL and testbench
===============================

POPCOUNT_ACC -- requirements
Module: popcount_acc

Interface
REQ-001 Parameter N, default 21, input bits per beat.
REQ-002 Parameter ACC_W, default 8, signed accumulator and result width, SHALL be at least clog2(N+1)+1.
REQ-003 Parameter PC_W, derived as clog2(N+1), per-beat popcount width; SHALL NOT be overridden.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  beat valid.
REQ-008 in_ready  out  1  beat accepted when in_valid&in_ready.
REQ-009 in_pos  in  N  positive-weight activation mask.
REQ-010 in_neg  in  N  negative-weight activation mask.
REQ-011 in_last  in  1  final beat of the current vector.
REQ-012 threshold  in  ACC_W  signed firing threshold; held stable from first beat to out_valid.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  result consumed when out_valid&out_ready.
REQ-015 out_count  out  ACC_W  signed sum of (popcount(pos)-popcount(neg)) over all beats of the vector.
REQ-016 out_fire  out  1  out_count >= threshold (signed).
REQ-017 out_sat  out  1  saturation occurred on any beat of the vector.

Function
REQ-018 Stage S1 SHALL register d = popcount(in_pos)-popcount(in_neg) (signed, PC_W+1 bits), plus v1=1 and last1=in_last, on each accepted beat; otherwise v1=0.
REQ-019 A bit set in both in_pos and in_neg SHALL contribute 0; popcount is exact, not approximate.
REQ-020 Stage S2, when v1=1: sum = acc + sign-extended d; clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; set sticky sat flag on clamp.
REQ-021 When v1&~last1: acc <= clamped sum.
REQ-022 When v1&last1: out_count <= clamped sum, out_sat <= sticky|clamp-now, out_fire <= compare, out_valid <= 1; acc and sticky cleared to 0 in the same cycle.
REQ-023 Latency: out_valid SHALL rise exactly 2 cycles after the accepting edge of the last beat.
REQ-024 in_ready = ~out_valid & ~(v1&last1); no beat is accepted while a result is pending or a last beat is in S1.
REQ-025 out_valid, out_count, out_fire, out_sat SHALL hold unchanged until out_valid&out_ready; out_valid then drops next cycle.
REQ-026 After the handshake, in_ready rises in the same cycle out_valid falls; a new vector needs no idle cycle beyond that.
REQ-027 in_valid while in_ready=0 SHALL be ignored (no beat captured, no error).
REQ-028 Single-beat vectors (in_last on first beat) SHALL be legal, with latency per REQ-023.
REQ-029 Vectors of unbounded length are legal; saturation prevents wrap-around.

Reset
REQ-030 On rst=1 at a clock edge: v1, last1, d, acc, sticky, out_valid, out_count, out_fire, out_sat all become 0; in_ready is 1 the following cycle.
REQ-031 Reset mid-vector SHALL discard all partial accumulation; the next accepted beat starts a new vector.
REQ-032 Reset SHALL override a simultaneous out handshake or beat acceptance.

Structure
REQ-033 Shared package popcount_pkg SHALL hold clog2-based width helpers and the saturating-add function.
REQ-034 Combinational sub-module popcount_tree #(N) SHALL compute one popcount; popcount_acc instantiates two (pos, neg).
REQ-035 Target size 120-400 lines RTL total.

Verification (N=21, ACC_W=8 unless stated)
REQ-036 One beat pos=0x1FFFFF, neg=0, last, threshold=10 -> out_valid 2 cycles later, out_count=21, out_fire=1, out_sat=0.
REQ-037 Three beats pos=0x1FFFFF, neg=0x00000F; last on third -> out_count=51; in_ready=1 between beats.
REQ-038 ACC_W=6: two beats pos=0x1FFFFF, neg=0 -> out_count=31, out_sat=1; next vector pos=0x1 -> out_count=1, out_sat=0.
REQ-039 pos=neg=0x1FFFFF, threshold=0 -> out_count=0, out_fire=1; threshold=1 -> out_fire=0.
REQ-040 out_ready low 5 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored; release -> one handshake, in_ready=1 next cycle.
REQ-041 Two beats of pos=0x7, then rst, then one beat pos=0x3 last -> out_count=2, no result emitted for the aborted vector.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared width helpers and the clamping adder used by the popcount accumulator.
package popcount_pkg;

  function automatic int pc_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic        clamp;
    logic [31:0] val;
  } sat_res_t;

  // Signed add of a and b, clamped to the range of a w-bit two's complement value.
  function automatic sat_res_t sat_add(input int a, input int b, input int w);
    int       hi;
    int       lo;
    int       s;
    sat_res_t r;
    hi      = (1 << (w - 1)) - 1;
    lo      = -(1 << (w - 1));
    s       = a + b;
    r.clamp = 1'b0;
    r.val   = s;
    if (s > hi) begin
      r.val   = hi;
      r.clamp = 1'b1;
    end else if (s < lo) begin
      r.val   = lo;
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of an N-bit vector; zero latency, no flow control.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter  int N    = 21,
  localparam int PC_W = pc_width(N)
) (
  input  logic [N-1:0]    vec,
  output logic [PC_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + PC_W'(vec[i]);
    end
  end

endmodule

// File: rtl/popcount_acc.sv
// Saturating signed accumulator of popcount(pos)-popcount(neg) per vector; result 2 cycles after the last beat.
// Input stalls while a result is pending or a last beat sits in the first stage; the result holds until taken.
module popcount_acc
  import popcount_pkg::*;
#(
  parameter int N     = 21,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_pos,
  input  logic [N-1:0]     in_neg,
  input  logic             in_last,
  input  logic [ACC_W-1:0] threshold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_count,
  output logic             out_fire,
  output logic             out_sat
);

  localparam int PC_W = pc_width(N);

  logic [PC_W-1:0]  pc_pos;
  logic [PC_W-1:0]  pc_neg;
  logic [PC_W:0]    diff;
  logic             accept;
  sat_res_t         sum_res;

  logic             v1_q, v1_d;
  logic             last1_q, last1_d;
  logic [PC_W:0]    d_q, d_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_count_q, out_count_d;
  logic             out_fire_q, out_fire_d;
  logic             out_sat_q, out_sat_d;

  popcount_tree #(.N(N)) u_pc_pos (.vec(in_pos), .cnt(pc_pos));
  popcount_tree #(.N(N)) u_pc_neg (.vec(in_neg), .cnt(pc_neg));

  assign in_ready  = ~out_valid_q & ~(v1_q & last1_q);
  assign accept    = in_valid & in_ready;
  assign diff      = $signed({1'b0, pc_pos}) - $signed({1'b0, pc_neg});
  assign sum_res   = sat_add(int'($signed(acc_q)), int'($signed(d_q)), ACC_W);

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_fire  = out_fire_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    v1_d        = accept;
    last1_d     = accept & in_last;
    d_d         = accept ? diff : d_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_fire_d  = out_fire_q;
    out_sat_d   = out_sat_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A last beat in S1 implies no result was pending when it was accepted,
    // so the result load below never collides with the handshake above.
    if (v1_q) begin
      if (last1_q) begin
        out_count_d = sum_res.val[ACC_W-1:0];
        out_sat_d   = sticky_q | sum_res.clamp;
        out_fire_d  = $signed(sum_res.val) >= int'($signed(threshold));
        out_valid_d = 1'b1;
        acc_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d       = sum_res.val[ACC_W-1:0];
        sticky_d    = sticky_q | sum_res.clamp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      d_q         <= '0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_fire_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      d_q         <= d_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_fire_q  <= out_fire_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_popcount_acc.sv
// Self-checking bench for popcount_acc: directed corner cases plus random vectors against a per-vector arithmetic model.
module tb_popcount_acc;

  localparam int N      = 21;
  localparam int ACC_W  = 8;
  localparam int ACC_W6 = 6;
  localparam logic [N-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, in_last, out_valid, out_ready, out_fire, out_sat;
  logic [N-1:0]     in_pos, in_neg;
  logic [ACC_W-1:0] threshold, out_count;

  logic              in_valid6, in_ready6, in_last6, out_valid6, out_ready6, out_fire6, out_sat6;
  logic [N-1:0]      in_pos6, in_neg6;
  logic [ACC_W6-1:0] threshold6, out_count6;

  popcount_acc #(.N(N), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_fire(out_fire), .out_sat(out_sat)
  );

  popcount_acc #(.N(N), .ACC_W(ACC_W6)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_pos(in_pos6), .in_neg(in_neg6), .in_last(in_last6), .threshold(threshold6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_count(out_count6),
    .out_fire(out_fire6), .out_sat(out_sat6)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [N-1:0] vp[$];
  logic [N-1:0] vn[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the beats queued in vp/vn as one vector and checks the result against
  // the arithmetic definition: running sum clamped to the signed range after every beat.
  task automatic run_vec(input int thr, input int gap_max, input int hold);
    int   acc, lo, hi;
    logic sat, fire;
    lo  = -(2 ** (ACC_W - 1));
    hi  = 2 ** (ACC_W - 1) - 1;
    acc = 0;
    sat = 1'b0;
    foreach (vp[i]) begin
      acc = acc + $countones(vp[i]) - $countones(vn[i]);
      if (acc > hi) begin acc = hi; sat = 1'b1; end
      if (acc < lo) begin acc = lo; sat = 1'b1; end
    end
    fire = (acc >= thr);

    threshold = 8'(thr);
    foreach (vp[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_pos   = N'($urandom);
        tick();
      end
      check("in_ready_beat", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_pos   = vp[i];
      in_neg   = vn[i];
      in_last  = (i == vp.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("no_early_valid", {31'b0, out_valid}, 32'd0);
    check("in_ready_last_in_s1", {31'b0, in_ready}, 32'd0);
    tick();
    check("latency_valid", {31'b0, out_valid}, 32'd1);
    check("count", 32'($signed(out_count)), 32'(acc));
    check("fire", {31'b0, out_fire}, {31'b0, fire});
    check("sat", {31'b0, out_sat}, {31'b0, sat});
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_pos   = N'($urandom);
      in_neg   = N'($urandom);
      in_last  = 1'($urandom);
      tick();
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_count", 32'($signed(out_count)), 32'(acc));
      check("hold_flags", {30'b0, out_fire, out_sat}, {30'b0, fire, sat});
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", {31'b0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    vp.delete();
    vn.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pos = '0; in_neg = '0; in_last = 1'b0; threshold = '0; out_ready = 1'b0;
    in_valid6 = 1'b0; in_pos6 = '0; in_neg6 = '0; in_last6 = 1'b0; threshold6 = '0; out_ready6 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_count", 32'($signed(out_count)), 32'd0);
    check("rst_flags", {30'b0, out_fire, out_sat}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_in_ready6", {31'b0, in_ready6}, 32'd1);

    // Single full beat, then three beats with some negatives.
    vp = '{ALL}; vn = '{21'h0};
    run_vec(10, 0, 0);
    vp = '{ALL, ALL, ALL}; vn = '{21'hF, 21'hF, 21'hF};
    run_vec(51, 0, 0);
    // Full cancellation against thresholds 0 and 1.
    vp = '{ALL}; vn = '{ALL};
    run_vec(0, 0, 0);
    vp = '{ALL}; vn = '{ALL};
    run_vec(1, 0, 0);
    // Consumer stalls five cycles while junk beats are offered.
    vp = '{21'h5, 21'h3}; vn = '{21'h0, 21'h1};
    run_vec(-3, 1, 5);
    // Positive and negative saturation, sticky after recovery.
    for (int i = 0; i < 8; i++) begin vp.push_back(ALL); vn.push_back(21'h0); end
    run_vec(127, 0, 0);
    for (int i = 0; i < 8; i++) begin vp.push_back(21'h0); vn.push_back(ALL); end
    run_vec(-128, 0, 0);
    for (int i = 0; i < 7; i++) begin vp.push_back(ALL); vn.push_back(21'h0); end
    for (int i = 0; i < 3; i++) begin vp.push_back(21'h0); vn.push_back(ALL); end
    run_vec(60, 0, 0);

    // Reset mid-vector discards two accepted beats.
    in_valid = 1'b1; in_pos = 21'h7; in_neg = '0; in_last = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_no_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("abort_no_valid2", {31'b0, out_valid}, 32'd0);
    vp = '{21'h3}; vn = '{21'h0};
    run_vec(0, 0, 0);

    // Reset wins over a simultaneous output handshake.
    threshold = 8'd0;
    in_valid = 1'b1; in_pos = ALL; in_neg = '0; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("rst_hs_valid", {31'b0, out_valid}, 32'd0);
    check("rst_hs_count", 32'($signed(out_count)), 32'd0);
    check("rst_hs_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("rst_hs_no_beat", {31'b0, out_valid}, 32'd0);

    // Narrow accumulator: 42 clamps to 31, then a clean vector.
    threshold6 = '0;
    in_valid6 = 1'b1; in_pos6 = ALL; in_neg6 = '0; in_last6 = 1'b0;
    tick();
    in_last6 = 1'b1;
    tick();
    in_valid6 = 1'b0; in_last6 = 1'b0;
    tick();
    check("w6_valid", {31'b0, out_valid6}, 32'd1);
    check("w6_count_sat", 32'($signed(out_count6)), 32'd31);
    check("w6_sat", {31'b0, out_sat6}, 32'd1);
    out_ready6 = 1'b1;
    tick();
    out_ready6 = 1'b0;
    in_valid6 = 1'b1; in_pos6 = 21'h1; in_last6 = 1'b1;
    tick();
    in_valid6 = 1'b0; in_last6 = 1'b0;
    tick();
    check("w6_valid2", {31'b0, out_valid6}, 32'd1);
    check("w6_count", 32'($signed(out_count6)), 32'd1);
    check("w6_nosat", {31'b0, out_sat6}, 32'd0);
    check("w6_fire", {31'b0, out_fire6}, 32'd1);
    out_ready6 = 1'b1;
    tick();
    out_ready6 = 1'b0;

    // Random vectors, dense masks mixed in to reach the clamps.
    for (int v = 0; v < 40; v++) begin
      int nb;
      nb = $urandom_range(1, 9);
      for (int b = 0; b < nb; b++) begin
        vp.push_back(($urandom_range(0, 3) == 0) ? ALL : N'($urandom));
        vn.push_back(($urandom_range(0, 3) == 0) ? ALL : N'($urandom));
      end
      run_vec($signed(8'($urandom)), 2, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
